// File: rtl/game_pkg.sv
// Shared runner-game definitions: obstacle FSM states, screen/player geometry
// (also used by the VGA renderer) and the random-timing LFSR constants.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2,
    ST_WON  = 2'd3
  } obst_state_t;

  localparam int SCREEN_W = 640;
  localparam int PLAYER_X = 80;
  localparam int PLAYER_W = 20;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16/14/13/11 expressed as a mask over q[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Widest slot array the free-slot encoder handles
  localparam int MAX_SLOTS = 8;

  // One-hot of the lowest set bit of free; all zeros when nothing is free
  function automatic logic [MAX_SLOTS-1:0] lowest_free(input logic [MAX_SLOTS-1:0] free);
    return free & (~free + MAX_SLOTS'(1));
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR free-running from a fixed non-zero seed.
module lfsr16 (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] q
);
  import game_pkg::*;

  // Shift every clock; the new LSB is the XOR of the tapped bits
  always_ff @(posedge clk) begin
    if (!reset_n) q <= LFSR_SEED;
    else          q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/obstacle_engine.sv
// Spawns, scrolls and retires obstacles on game ticks, and raises sticky
// collision / victory flags for the game FSM.
module obstacle_engine #(
  parameter int NUM_SLOTS = 4,
  parameter int SCREEN_W  = game_pkg::SCREEN_W,
  parameter int SPEED     = 4,
  parameter int PLAYER_X  = game_pkg::PLAYER_X,
  parameter int PLAYER_W  = game_pkg::PLAYER_W,
  parameter int OBST_W    = 16,
  parameter int OBST_H    = 40,
  parameter int GAP_MIN   = 40,
  parameter int WIN_COUNT = 30
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic                       run,
  input  logic [9:0]                 jump_height,
  output logic [NUM_SLOTS-1:0][10:0] obst_x,
  output logic [NUM_SLOTS-1:0]       obst_valid,
  output logic [4:0]                 passed_count,
  output logic                       player_death,
  output logic                       win
);
  import game_pkg::*;

  localparam logic [11:0] HIT_RIGHT = 12'(PLAYER_X + PLAYER_W);
  localparam logic [11:0] HIT_LEFT  = 12'(PLAYER_X);
  localparam logic [7:0]  GAP_BASE  = 8'(GAP_MIN);

  obst_state_t state_reg, state_next;

  logic [15:0]                 lfsr_q;
  logic                        unused_bits;
  logic [NUM_SLOTS-1:0]        valid_reg, retire, hit, pick;
  logic [NUM_SLOTS-1:0][10:0]  x_reg;
  logic [MAX_SLOTS-1:0]        free_wide, pick_wide;
  logic [6:0]                  gap_reg, gap_next, gap_inc;
  logic [4:0]                  passed_reg, passed_next;
  logic [5:0]                  passed_sum;
  logic [3:0]                  retire_cnt;
  logic                        any_free, spawn, tick_run, clear_all, collide, won;
  logic                        death_reg, win_reg;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr_q)
  );

  assign unused_bits = ^{lfsr_q[15:5], pick_wide};

  assign tick_run  = tick && (state_reg == ST_RUN);
  // Every path into IDLE wipes the play field on the same edge
  assign clear_all = (state_next == ST_IDLE);
  assign any_free  = ~&valid_reg;
  assign gap_inc   = (gap_reg == 7'd127) ? gap_reg : gap_reg + 7'd1;
  assign spawn     = tick_run && any_free &&
                     ({1'b0, gap_inc} >= GAP_BASE + {3'b000, lfsr_q[4:0]});
  assign collide   = (|hit) && (jump_height < 10'(OBST_H));
  assign won       = (passed_reg == 5'(WIN_COUNT));

  // Pick the lowest slot that was free before this tick
  always_comb begin
    free_wide                = '0;
    free_wide[NUM_SLOTS-1:0] = ~valid_reg;
    pick_wide                = lowest_free(free_wide);
    pick                     = pick_wide[NUM_SLOTS-1:0];
  end

  // Count retirements and saturate the pass counter at the victory target
  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) retire_cnt = retire_cnt + {3'b000, retire[i]};
    passed_sum  = {1'b0, passed_reg} + {2'b00, retire_cnt};
    passed_next = passed_sum[4:0];
    if (clear_all)                          passed_next = '0;
    else if (passed_sum >= 6'(WIN_COUNT))   passed_next = 5'(WIN_COUNT);
  end

  // Gap counter: cleared by a spawn, frozen while every slot is busy
  always_comb begin
    gap_next = gap_reg;
    if (clear_all)                 gap_next = '0;
    else if (spawn)                gap_next = '0;
    else if (tick_run && any_free) gap_next = gap_inc;
  end

  // Next-state: abort beats everything, collision beats victory
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (run) state_next = ST_RUN;
      ST_RUN: begin
        if (!run)         state_next = ST_IDLE;
        else if (collide) state_next = ST_DEAD;
        else if (won)     state_next = ST_WON;
      end
      ST_DEAD, ST_WON: if (!run) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Counters and sticky flags, registered alongside the state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gap_reg    <= '0;
      passed_reg <= '0;
      death_reg  <= 1'b0;
      win_reg    <= 1'b0;
    end else begin
      gap_reg    <= gap_next;
      passed_reg <= passed_next;
      death_reg  <= (state_next == ST_DEAD);
      win_reg    <= (state_next == ST_WON);
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic        valid_slot_reg;
    logic [10:0] x_slot_reg;
    logic [11:0] x_ext;

    assign x_ext      = {1'b0, x_slot_reg};
    assign retire[gi] = tick_run && valid_slot_reg && (x_slot_reg < 11'(SPEED));
    assign hit[gi]    = valid_slot_reg && (x_ext < HIT_RIGHT) &&
                        (x_ext + 12'(OBST_W) > HIT_LEFT);

    // Slot register: spawn, retire or scroll on a run tick
    always_ff @(posedge clk) begin
      if (!reset_n || clear_all) begin
        valid_slot_reg <= 1'b0;
        x_slot_reg     <= '0;
      end else if (tick_run) begin
        if (spawn && pick[gi]) begin
          valid_slot_reg <= 1'b1;
          x_slot_reg     <= 11'(SCREEN_W);
        end else if (retire[gi]) begin
          valid_slot_reg <= 1'b0;
        end else if (valid_slot_reg) begin
          x_slot_reg <= x_slot_reg - 11'(SPEED);
        end
      end
    end

    assign valid_reg[gi] = valid_slot_reg;
    assign x_reg[gi]     = x_slot_reg;
  end

  assign obst_x       = x_reg;
  assign obst_valid   = valid_reg;
  assign passed_count = passed_reg;
  assign player_death = death_reg;
  assign win          = win_reg;

endmodule

// File: tb/tb_obstacle_engine.sv
// Randomized bench for obstacle_engine against a cycle-level behavioural model
// of the game rules (slots as plain arrays, rules applied in order each edge).
module tb_obstacle_engine;

  localparam int NS        = 4;
  localparam int SCREEN_W  = 640;
  localparam int SPEED     = 4;
  localparam int PLAYER_X  = 80;
  localparam int PLAYER_W  = 20;
  localparam int OBST_W    = 16;
  localparam int OBST_H    = 40;
  localparam int GAP_MIN   = 12;
  localparam int WIN_COUNT = 3;

  localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2, M_WON = 3;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                tick = 1'b0;
  logic                run = 1'b0;
  logic [9:0]          jump_height = '0;
  logic [NS-1:0][10:0] obst_x;
  logic [NS-1:0]       obst_valid;
  logic [4:0]          passed_count;
  logic                player_death;
  logic                win;

  always #5 clk = ~clk;

  obstacle_engine #(
    .NUM_SLOTS (NS),
    .SCREEN_W  (SCREEN_W),
    .SPEED     (SPEED),
    .PLAYER_X  (PLAYER_X),
    .PLAYER_W  (PLAYER_W),
    .OBST_W    (OBST_W),
    .OBST_H    (OBST_H),
    .GAP_MIN   (GAP_MIN),
    .WIN_COUNT (WIN_COUNT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .run          (run),
    .jump_height  (jump_height),
    .obst_x       (obst_x),
    .obst_valid   (obst_valid),
    .passed_count (passed_count),
    .player_death (player_death),
    .win          (win)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_state;
  int          m_gap;
  int          m_passed;
  int          m_x [NS];
  bit          m_v [NS];
  logic [15:0] m_lfsr;
  int          prio_seen = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_state  = M_IDLE;
    m_gap    = 0;
    m_passed = 0;
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 0;
      m_v[i] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    model_clear();
    m_lfsr = 16'hACE1;
  endfunction

  function automatic bit model_overlap();
    for (int i = 0; i < NS; i++)
      if (m_v[i] && m_x[i] < PLAYER_X + PLAYER_W && m_x[i] + OBST_W > PLAYER_X) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_nvalid();
    int n = 0;
    for (int i = 0; i < NS; i++) n += int'(m_v[i]);
    return n;
  endfunction

  // One game tick: scroll/retire everything, then maybe spawn into a pre-tick free slot
  function automatic void model_tick();
    int f = -1;
    int nret = 0;
    int ng;
    for (int i = 0; i < NS; i++) if (!m_v[i] && f < 0) f = i;
    ng = (m_gap + 1 > 127) ? 127 : m_gap + 1;
    for (int i = 0; i < NS; i++) begin
      if (m_v[i]) begin
        if (m_x[i] < SPEED) begin
          m_v[i] = 1'b0;
          nret++;
        end else begin
          m_x[i] -= SPEED;
        end
      end
    end
    if (f >= 0) begin
      if (ng >= GAP_MIN + int'(m_lfsr[4:0])) begin
        m_v[f] = 1'b1;
        m_x[f] = SCREEN_W;
        m_gap  = 0;
      end else begin
        m_gap = ng;
      end
    end
    m_passed = (m_passed + nret > WIN_COUNT) ? WIN_COUNT : m_passed + nret;
  endfunction

  function automatic void model_edge(bit rst_n, bit tk, bit rn, int jh);
    bit dead;
    bit done_win;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_state)
      M_IDLE: if (rn) m_state = M_RUN;
      M_RUN: begin
        if (!rn) begin
          model_clear();
        end else begin
          dead     = model_overlap() && (jh < OBST_H);
          done_win = (m_passed == WIN_COUNT);
          if (tk) model_tick();
          if (dead) m_state = M_DEAD;
          else if (done_win) m_state = M_WON;
          if (dead && done_win) prio_seen++;
        end
      end
      default: if (!rn) model_clear();
    endcase
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endfunction

  task automatic compare_all();
    logic [NS-1:0] ev;
    for (int i = 0; i < NS; i++) ev[i] = m_v[i];
    check("valid", obst_valid, ev);
    check("passed", passed_count, m_passed);
    check("death", player_death, m_state == M_DEAD);
    check("win", win, m_state == M_WON);
    for (int i = 0; i < NS; i++) begin
      if (m_v[i])                check($sformatf("x%0d", i), obst_x[i], m_x[i]);
      else if (m_state == M_IDLE) check($sformatf("x%0d_idle", i), obst_x[i], 0);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare
  task automatic step(bit rst_n, bit tk, bit rn, int jh);
    reset_n     = rst_n;
    tick        = tk;
    run         = rn;
    jump_height = 10'(jh);
    @(posedge clk);
    model_edge(rst_n, tk, rn, jh);
    #1;
    compare_all();
  endtask

  function automatic int hi_jump();
    case ($urandom_range(0, 3))
      0:       return 40;
      1:       return 41;
      2:       return 100;
      default: return 1023;
    endcase
  endfunction

  function automatic int lo_jump();
    return ($urandom_range(0, 1) == 0) ? 0 : 39;
  endfunction

  // mode 0: grounded, 1: always clears, 2: mostly clears, 3: abort at 3 valid
  task automatic play_game(int mode, int idx);
    int cyc = 0;
    bit prev = 1'b0;
    bit tk;
    int jh;
    bit done = 1'b0;
    while (!done && cyc < 6000) begin
      tk = !prev && ($urandom_range(0, 3) != 0);
      case (mode)
        0:       jh = lo_jump();
        1, 3:    jh = hi_jump();
        default: jh = ($urandom_range(0, 63) == 0) ? lo_jump() : hi_jump();
      endcase
      if (mode == 2 && m_state == M_RUN && m_passed == WIN_COUNT && model_overlap()) jh = 0;
      if (mode == 3 && m_state == M_RUN && model_nvalid() == 3) begin
        step(1'b1, tk, 1'b0, jh);
        done = 1'b1;
      end else begin
        step(1'b1, tk, 1'b1, jh);
        if (m_state == M_DEAD || m_state == M_WON) done = 1'b1;
      end
      prev = tk;
      cyc++;
    end
    check("game_end", done, 1);
    $display("game %0d mode %0d end_state %0d passed %0d cycles %0d", idx, mode, m_state, m_passed, cyc);
  endtask

  // Keep ticking after the game ended: everything must stay frozen
  task automatic freeze_phase();
    for (int i = 0; i < 8; i++) step(1'b1, i[0], 1'b1, ($urandom_range(0, 1) == 0) ? 0 : 200);
  endtask

  task automatic idle_phase();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 0);
  endtask

  initial begin
    int modes [14] = '{0, 1, 3, 2, 2, 2, 2, 2, 2, 2, 2, 0, 1, 3};
    model_reset();
    // Reset held with run high and ticks arriving: nothing may move
    for (int i = 0; i < 6; i++) step(1'b0, i[0], 1'b1, 0);

    for (int g = 0; g < 14; g++) begin
      play_game(modes[g], g);
      if (modes[g] != 3) freeze_phase();
      if (g == 0) step(1'b0, 1'b1, 1'b1, 0);   // reset pulse while DEAD
      idle_phase();
    end
    $display("collision-over-victory cases seen: %0d", prio_seen);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
